// File: rtl/pong_game_ctrl.sv
// Pong game-flow controller: sequences new game, play, ball respawn pause and
// game-over pause, and drives the score counter and graphics-freeze strobes.
module pong_game_ctrl #(
  parameter int BALLS       = 3,
  parameter int TIMER_TICKS = 120
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] btn,
  input  logic       hit,
  input  logic       miss,
  input  logic       refr_tick,
  output logic       d_inc,
  output logic       d_clr,
  output logic       gra_still,
  output logic [1:0] balls_left,
  output logic [1:0] game_state
);

  typedef enum logic [1:0] {
    NEWGAME = 2'b00,
    PLAY    = 2'b01,
    NEWBALL = 2'b10,
    OVER    = 2'b11
  } state_t;

  localparam logic [1:0] BALLS_INIT = 2'(BALLS);
  localparam logic [6:0] TICKS_INIT = 7'(TIMER_TICKS);

  state_t     state, state_next;
  logic [1:0] balls_next;
  logic [6:0] timer;
  logic       timer_start, timer_up, pressed;
  logic       inc_next, clr_next;

  assign pressed    = (btn != 2'b00);
  assign timer_up   = (timer == 7'd0);
  assign gra_still  = (state != PLAY);
  assign game_state = state;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of its neighbours, independent of block order.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state      <= NEWGAME;
      balls_left <= BALLS_INIT;
      timer      <= 7'd0;
      d_inc      <= 1'b0;
      d_clr      <= 1'b0;
    end else begin
      state      <= state_next;
      balls_left <= balls_next;
      d_inc      <= inc_next;
      d_clr      <= clr_next;
      // A fresh load beats a decrement arriving in the same cycle.
      if (timer_start)
        timer <= TICKS_INIT;
      else if (refr_tick && !timer_up)
        timer <= timer - 7'd1;
    end
  end

  // NOTE: every output of this block gets a default first, so no path leaves
  // a signal unassigned and no latch is inferred.
  always_comb begin
    state_next  = state;
    balls_next  = balls_left;
    timer_start = 1'b0;
    inc_next    = 1'b0;
    clr_next    = 1'b0;
    unique case (state)
      NEWGAME: begin
        if (pressed) begin
          state_next = PLAY;
          balls_next = BALLS_INIT - 2'd1;
          clr_next   = 1'b1;
        end
      end
      PLAY: begin
        // A simultaneous hit and miss counts only as a miss.
        if (miss) begin
          timer_start = 1'b1;
          if (balls_left != 2'd0) begin
            balls_next = balls_left - 2'd1;
            state_next = NEWBALL;
          end else begin
            state_next = OVER;
          end
        end else if (hit) begin
          inc_next = 1'b1;
        end
      end
      NEWBALL: begin
        if (timer_up && pressed)
          state_next = PLAY;
      end
      OVER: begin
        if (timer_up) begin
          state_next = NEWGAME;
          balls_next = BALLS_INIT;
        end
      end
      default: state_next = NEWGAME;
    endcase
  end

endmodule
